// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: owns the register-file write port and shares it between two writeback requesters.
//
// Ports:
//   clk, rst                   clock and synchronous active-low reset (0 = reset)
//   a_valid/a_ready/a_addr/a_data
//                              requester A (ALU result), valid/ready handshake
//   b_valid/b_ready/b_addr/b_data
//                              requester B (load result), valid/ready handshake
//   rf_we, rf_waddr, rf_wdata  registered write port (RFWr, A3, WD)
//   busy                       post-reset clear sweep in progress
//   rf_raddr1/2, rf_rdata1/2, fwd_data1/2
//                              read-side forwarding, present only when RF_BYPASS_EN is defined
//
// After reset the block writes zero to registers 1..NUM_REGS-1, one per cycle, so the
// register file needs no reset of its own. Grants then alternate round-robin between
// A and B whenever both are requesting.
module rf_write_arbiter #(
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned NUM_REGS       = 32,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
`ifdef RF_BYPASS_EN
  input  logic [ADDR_W-1:0] rf_raddr1,
  input  logic [ADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2,
`endif
  output logic              busy
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t            state, state_n;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_n;
  logic              rr_ptr, rr_ptr_n;
  logic              busy_n, we_n;
  logic [ADDR_W-1:0] waddr_n, sel_addr;
  logic [DATA_W-1:0] wdata_n;
  logic              run, a_fire, b_fire;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= CLEAR_ON_RESET ? CLEAR : RUN;
      busy     <= CLEAR_ON_RESET;
      clr_cnt  <= ADDR_W'(1);
      rr_ptr   <= 1'b0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      state    <= state_n;
      busy     <= busy_n;
      clr_cnt  <= clr_cnt_n;
      rr_ptr   <= rr_ptr_n;
      rf_we    <= we_n;
      rf_waddr <= waddr_n;
      rf_wdata <= wdata_n;
    end
  end
  // rr_ptr: 0 = A has priority, 1 = B has priority. The two readies are mutually
  // exclusive whenever both sides are valid, so at most one transfer per cycle.
  always_comb begin
    run       = state == RUN;
    a_ready   = run && (!b_valid || !rr_ptr);
    b_ready   = run && (!a_valid || rr_ptr);
    a_fire    = a_valid && a_ready;
    b_fire    = b_valid && b_ready;
    sel_addr  = a_fire ? a_addr : b_addr;
    state_n   = state;
    busy_n    = busy;
    clr_cnt_n = clr_cnt;
    rr_ptr_n  = rr_ptr;
    we_n      = 1'b0;
    waddr_n   = rf_waddr;
    wdata_n   = rf_wdata;
    if (!run) begin
      we_n      = 1'b1;
      waddr_n   = clr_cnt;
      wdata_n   = '0;
      clr_cnt_n = clr_cnt + 1'b1;
      if (clr_cnt == ADDR_W'(NUM_REGS - 1)) begin
        state_n = RUN;
        busy_n  = 1'b0;
      end
    end else begin
      rr_ptr_n = a_fire ? 1'b1 : b_fire ? 1'b0 : rr_ptr;
      // Writes to register 0 complete the handshake but never reach the RF.
      we_n     = (a_fire || b_fire) && sel_addr != '0;
      waddr_n  = we_n ? sel_addr : rf_waddr;
      wdata_n  = we_n ? (a_fire ? a_data : b_data) : rf_wdata;
    end
  end
`ifdef RF_BYPASS_EN
  // Same-cycle write-to-read forwarding; register 0 always reads from the RF.
  assign fwd_data1 = (rf_we && rf_waddr == rf_raddr1 && rf_raddr1 != '0) ? rf_wdata : rf_rdata1;
  assign fwd_data2 = (rf_we && rf_waddr == rf_raddr2 && rf_raddr2 != '0) ? rf_wdata : rf_rdata2;
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed vector bench for rf_write_arbiter.
module tb_rf_write_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [4:0]  a_addr, b_addr, rf_waddr;
  logic [31:0] a_data, b_data, rf_wdata;
  logic        rf_we, busy;
  int          total = 0;
  int          bad   = 0;
`ifdef RF_BYPASS_EN
  logic [4:0]  rf_raddr1 = '0, rf_raddr2 = '0;
  logic [31:0] rf_rdata1 = '0, rf_rdata2 = '0, fwd_data1, fwd_data2;
`endif
  rf_write_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
`ifdef RF_BYPASS_EN
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
`endif
    .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        ear, ebr, ewe;
    logic [4:0]  ewa;
    logic [31:0] ewd;
  } vec_t;
  vec_t vecs [11];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  // n edges of the clear sweep, starting from the first edge after reset release
  task automatic sweep(input int n);
    a_valid = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      chk($sformatf("sweep%0d_we", k), 32'(rf_we), 32'd1);
      chk($sformatf("sweep%0d_addr", k), 32'(rf_waddr), 32'(k));
      chk($sformatf("sweep%0d_data", k), rf_wdata, 32'd0);
      chk($sformatf("sweep%0d_busy", k), 32'(busy), (k < 31) ? 32'd1 : 32'd0);
      if (k < 31) chk($sformatf("sweep%0d_a_ready", k), 32'(a_ready), 32'd0);
    end
    a_valid = 1'b0;
  endtask
  initial begin
    //            av aa     ad            bv ba     bd            ar br we wa     wd
    vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h12345678, 1'b0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 5'd3, 32'h11,       1'b1, 5'd4, 32'hA1,       1'b1, 1'b0, 1'b1, 5'd3, 32'h11};
    vecs[4]  = '{1'b1, 5'd3, 32'h22,       1'b1, 5'd4, 32'hA1,       1'b0, 1'b1, 1'b1, 5'd4, 32'hA1};
    vecs[5]  = '{1'b1, 5'd3, 32'h22,       1'b1, 5'd4, 32'hA2,       1'b1, 1'b0, 1'b1, 5'd3, 32'h22};
    vecs[6]  = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd4, 32'hA2,       1'b0, 1'b1, 1'b1, 5'd4, 32'hA2};
    vecs[7]  = '{1'b1, 5'd3, 32'h33,       1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 5'd3, 32'h33};
    vecs[8]  = '{1'b1, 5'd9, 32'h100,      1'b1, 5'd9, 32'h200,      1'b0, 1'b1, 1'b1, 5'd9, 32'h200};
    vecs[9]  = '{1'b1, 5'd9, 32'h100,      1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 5'd9, 32'h100};
    vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 1'b0, 5'd9, 32'h100};
    rst = 1'b0; a_valid = 1'b1; b_valid = 1'b0;
    a_addr = '0; a_data = '0; b_addr = '0; b_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_addr", 32'(rf_waddr), 32'd0);
    chk("rst_data", rf_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    @(negedge clk) rst = 1'b1;
    sweep(31);
    @(posedge clk); #1;
    chk("post_sweep_we", 32'(rf_we), 32'd0);
    chk("post_sweep_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      a_valid = vecs[i].av; a_addr = vecs[i].aa; a_data = vecs[i].ad;
      b_valid = vecs[i].bv; b_addr = vecs[i].ba; b_data = vecs[i].bd;
      #1;
      chk($sformatf("v%0d_a_ready", i), 32'(a_ready), 32'(vecs[i].ear));
      chk($sformatf("v%0d_b_ready", i), 32'(b_ready), 32'(vecs[i].ebr));
      @(posedge clk); #1;
      chk($sformatf("v%0d_we", i), 32'(rf_we), 32'(vecs[i].ewe));
      chk($sformatf("v%0d_addr", i), 32'(rf_waddr), 32'(vecs[i].ewa));
      chk($sformatf("v%0d_data", i), rf_wdata, vecs[i].ewd);
    end
`ifdef RF_BYPASS_EN
    @(negedge clk);
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'hCAFE;
    @(posedge clk); #1;
    a_valid = 1'b0;
    rf_raddr1 = 5'd7; rf_rdata1 = 32'h0; rf_raddr2 = 5'd6; rf_rdata2 = 32'h66;
    #1;
    chk("fwd1_hit", fwd_data1, 32'hCAFE);
    chk("fwd2_miss", fwd_data2, 32'h66);
    rf_raddr1 = 5'd0; rf_rdata1 = 32'h55; rf_raddr2 = 5'd7; rf_rdata2 = 32'h3;
    #1;
    chk("fwd1_zero", fwd_data1, 32'h55);
    chk("fwd2_hit", fwd_data2, 32'hCAFE);
`endif
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    chk("rst2_we", 32'(rf_we), 32'd0);
    chk("rst2_busy", 32'(busy), 32'd1);
    @(negedge clk) rst = 1'b1;
    sweep(10);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_we", 32'(rf_we), 32'd0);
    chk("mid_rst_addr", 32'(rf_waddr), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("mid_rst_we2", 32'(rf_we), 32'd0);
    @(negedge clk) rst = 1'b1;
    sweep(31);
    @(posedge clk); #1;
    chk("post_sweep2_we", 32'(rf_we), 32'd0);
    chk("post_sweep2_busy", 32'(busy), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Owns the single write port (A3/WD/RFWr) of the 32x32 register file.
- Shares that port between two writeback requesters, A (ALU result) and B (load result), using valid/ready handshakes and round-robin arbitration.
- After reset, sequences a clear sweep that writes zero to registers 1..31, so the register file itself needs no reset loop.
- Sits between the pipeline writeback stage and the register file; write outputs are registered.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- NUM_REGS, 32, register count; the clear sweep covers 1..NUM_REGS-1.
- CLEAR_ON_RESET, 1, 1 = run the clear sweep after reset; 0 = enter RUN directly.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- a_valid  in  1  requester A has a write pending.
- a_ready  out  1  A accepted this cycle when a_valid and a_ready are both 1.
- a_addr  in  ADDR_W  A destination register.
- a_data  in  DATA_W  A write data.
- b_valid, b_ready, b_addr, b_data: same meaning as the A ports, for requester B.
- rf_we  out  1  register file write enable (RFWr).
- rf_waddr  out  ADDR_W  register file write address (A3).
- rf_wdata  out  DATA_W  register file write data (WD).
- busy  out  1  clear sweep in progress.

Behaviour:
- Reset: rst==0 at a posedge sets:
  - rf_we=0, rf_waddr=0, rf_wdata=0;
  - clr_cnt=1, rr_ptr=A;
  - state=CLEAR and busy=1 if CLEAR_ON_RESET, else state=RUN and busy=0.
  - Reset has priority over everything and may occur mid-sweep or mid-transfer; the sweep restarts at 1 and any pending write is dropped.
- States: CLEAR and RUN only.
- CLEAR:
  - Each cycle registers rf_we=1, rf_waddr=clr_cnt, rf_wdata=0, then clr_cnt increments.
  - In the cycle that issues address NUM_REGS-1, next state=RUN and busy<=0.
  - The sweep takes exactly 31 consecutive write cycles, starting the first cycle after rst returns to 1.
  - a_ready=b_ready=0 throughout CLEAR.
- RUN readies (combinational):
  - a_ready = RUN && (!b_valid || rr_ptr==A).
  - b_ready = RUN && (!a_valid || rr_ptr==B).
  - The two readies never both imply a transfer in the same cycle.
- Round robin:
  - After a transfer from A, rr_ptr<=B; after a transfer from B, rr_ptr<=A.
  - No transfer: rr_ptr holds.
- Latency:
  - A transfer in cycle N gives rf_we=1, rf_waddr, rf_wdata in cycle N+1.
  - No transfer in N gives rf_we=0 in N+1; rf_waddr and rf_wdata hold their last values.
- Address 0: the transfer is accepted (handshake completes, rr_ptr updates) but rf_we stays 0.
- Same address from A and B back-to-back: writes are serialized in grant order, so the later grant wins in the RF.
- Throughput: 1 write per cycle; continuous dual requests alternate A,B,A,B.
- Sources must hold valid, addr and data stable until accepted; the block does not buffer a request before accepting it.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - Adds inputs rf_raddr1, rf_raddr2 (ADDR_W), which mirror A1/A2, and rf_rdata1, rf_rdata2 (DATA_W), which mirror RD1/RD2.
  - Adds outputs fwd_data1, fwd_data2 (DATA_W).
  - fwd_dataK = rf_wdata when rf_we && rf_waddr==rf_raddrK && rf_raddrK!=0, else rf_rdataK.
  - Purely combinational.
  - Gives same-cycle write-to-read forwarding.
- Undefined: these ports and this logic are absent; readers use RD1/RD2 directly.

Test Plan:
- Clear sweep: hold rst=0 for 2 cycles, then rst=1 -> rf_we=1 for 31 consecutive cycles, rf_waddr 1..31 in order, rf_wdata=0 throughout; busy=1 during the sweep, 0 after; a_ready=0 while busy.
- Single A write: a_valid=1, a_addr=5, a_data=0xDEADBEEF in cycle N -> a_ready=1 in N; rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in N+1; rf_we=0 in N+2.
- Arbitration: a_valid=b_valid=1 for 4 cycles, A data 0x11/0x22, B data 0xA1/0xA2 -> RF writes A(0x11), B(0xA1), A(0x22), B(0xA2).
- Zero-register write: b_valid=1, b_addr=0, b_data=0x12345678 -> b_ready=1, rf_we stays 0.
- Reset mid-sweep: drive rst=0 while rf_waddr=10 -> next cycles rf_we=0; after release the sweep restarts at 1 and runs all 31 writes.
- (RF_BYPASS_EN) Forwarding: rf_we=1, rf_waddr=7, rf_wdata=0xCAFE, rf_raddr1=7, rf_rdata1=0 -> fwd_data1=0xCAFE; with rf_raddr1=0 -> fwd_data1=rf_rdata1.
